// File: rtl/aes_pkg.sv
// Shared AES decrypt-side constants: inverse S-box table, FSM state encoding,
// and the step-count helper for the lane-parallel byte substitution unit.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int LANES_DEF = 4;

    // Processing cycles per 16-byte block for a given lane count.
    function automatic int nstep_of(input int lanes);
        return 16 / lanes;
    endfunction

    localparam int NSTEP = nstep_of(LANES_DEF);

    // Inverse S-box: index = input byte (high nibble = row, low nibble = column).
    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_s_box_byte.sv
// Single-byte inverse S-box lookup; purely combinational.
module inv_s_box_byte
    import aes_pkg::*;
(
    input  logic [7:0] raw,
    output logic [7:0] sub
);

    assign sub = INV_SBOX[raw];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential inverse SubBytes: accepts a 128-bit state, substitutes LANES bytes
// per cycle through the inverse S-box, and holds the result until accepted.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = LANES_DEF
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int N_STEP = nstep_of(LANES);
    localparam int STEP_W = (N_STEP > 1) ? $clog2(N_STEP) : 1;

    if (16 % LANES != 0) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must divide 16");
    end

    state_e                  state, state_nxt;
    logic [15:0][7:0]        state_reg;
    logic [STEP_W-1:0]       step;
    logic                    last_step;
    logic [LANES-1:0][3:0]   lane_idx;
    logic [LANES-1:0][7:0]   lane_raw;
    logic [LANES-1:0][7:0]   lane_sub;

    assign last_step = (step == STEP_W'(N_STEP - 1));
    assign out_data  = state_reg;

    // Lane k works on byte step*LANES+k of the held state.
    always_comb begin
        lane_idx = '0;
        lane_raw = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_idx[k] = 4'(int'(step) * LANES + k);
            lane_raw[k] = state_reg[lane_idx[k]];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        inv_s_box_byte u_sbox (
            .raw (lane_raw[g]),
            .sub (lane_sub[g])
        );
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; handshake outputs depend on the registered state only.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, overwrite LANES bytes per BUSY cycle.
    // step returns to zero after the last slice so it never wraps past NSTEP-1.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg <= '0;
            step      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= in_data;
                        step      <= '0;
                    end
                end
                BUSY: begin
                    for (int k = 0; k < LANES; k++)
                        state_reg[lane_idx[k]] <= lane_sub[k];
                    step <= last_step ? '0 : step + STEP_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
